// File: rtl/logo_motion_if.sv
// Bus between the frame source and the logo motion generator.
// Frame/pause flow in; position, direction and colour flow out.
interface logo_motion_if;
    logic [31:0] frame;
    logic        pause;
    logic [9:0]  logo_x;
    logic [8:0]  logo_y;
    logic [2:0]  hue;
    logic        dir_x;
    logic        dir_y;
    logic        corner_hit;
    logic [15:0] corner_count;

    modport master (
        output frame,
        output pause,
        input  logo_x,
        input  logo_y,
        input  hue,
        input  dir_x,
        input  dir_y,
        input  corner_hit,
        input  corner_count
    );

    modport slave (
        input  frame,
        input  pause,
        output logo_x,
        output logo_y,
        output hue,
        output dir_x,
        output dir_y,
        output corner_hit,
        output corner_count
    );
endinterface

// File: rtl/logo_motion.sv
// Bouncing-logo motion generator: steps the logo once per FRAME_DIV frames,
// reflects at the visible-area edges and bumps the hue on every bounce.
module logo_motion #(
    parameter int H_VISIBLE = 640,
    parameter int V_VISIBLE = 480,
    parameter int LOGO_W    = 128,
    parameter int LOGO_H    = 64,
    parameter int STEP_X    = 1,
    parameter int STEP_Y    = 1,
    parameter int FRAME_DIV = 1,
    parameter int INIT_X    = 0,
    parameter int INIT_Y    = 0
) (
    input  logic         clk_25_175,
    input  logic         rst,
    logo_motion_if.slave bus
);
    localparam int MAX_X = H_VISIBLE - LOGO_W;
    localparam int MAX_Y = V_VISIBLE - LOGO_H;
    localparam int DW    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(FRAME_DIV - 1);

    if (LOGO_W < 1 || LOGO_W >= H_VISIBLE || MAX_X > 1023) begin : g_bad_w
        $error("logo_motion: LOGO_W/H_VISIBLE out of range");
    end
    if (LOGO_H < 1 || LOGO_H >= V_VISIBLE || MAX_Y > 511) begin : g_bad_h
        $error("logo_motion: LOGO_H/V_VISIBLE out of range");
    end
    if (STEP_X < 1 || STEP_X > MAX_X) begin : g_bad_sx
        $error("logo_motion: STEP_X out of range");
    end
    if (STEP_Y < 1 || STEP_Y > MAX_Y) begin : g_bad_sy
        $error("logo_motion: STEP_Y out of range");
    end
    if (FRAME_DIV < 1) begin : g_bad_div
        $error("logo_motion: FRAME_DIV must be >= 1");
    end
    if (INIT_X < 0 || INIT_X > MAX_X) begin : g_bad_ix
        $error("logo_motion: INIT_X out of range");
    end
    if (INIT_Y < 0 || INIT_Y > MAX_Y) begin : g_bad_iy
        $error("logo_motion: INIT_Y out of range");
    end

    typedef enum logic {ST_ARM, ST_RUN} state_t;

    state_t          state_q, state_d;
    logic [31:0]     frame_q;
    logic            tick_q, tick_d;
    logic [DW-1:0]   div_q, div_d;
    logic [9:0]      x_q, x_d;
    logic [8:0]      y_q, y_d;
    logic            dx_q, dx_d;
    logic            dy_q, dy_d;
    logic [2:0]      hue_q, hue_d;
    logic            corner_q, corner_d;
    logic [15:0]     cc_q, cc_d;
    logic [10:0]     nx;
    logic [9:0]      ny;
    logic            bounce_x, bounce_y;

    // Strobe is registered so the update lands two edges after the frame change.
    always_comb begin
        state_d  = ST_RUN;
        tick_d   = (state_q == ST_RUN) && (bus.frame != frame_q) && !bus.pause;
        div_d    = div_q;
        x_d      = x_q;
        y_d      = y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        hue_d    = hue_q;
        corner_d = 1'b0;
        cc_d     = cc_q;
        bounce_x = 1'b0;
        bounce_y = 1'b0;
        nx       = {1'b0, x_q} + 11'(STEP_X);
        ny       = {1'b0, y_q} + 10'(STEP_Y);
        if (tick_q) begin
            if (div_q != DIV_LAST) begin
                div_d = div_q + 1'b1;
            end else begin
                div_d = '0;
                if (dx_q) begin
                    if (nx >= 11'(MAX_X)) begin
                        x_d      = 10'(MAX_X);
                        dx_d     = 1'b0;
                        bounce_x = 1'b1;
                    end else begin
                        x_d = nx[9:0];
                    end
                end else if (x_q <= 10'(STEP_X)) begin
                    x_d      = '0;
                    dx_d     = 1'b1;
                    bounce_x = 1'b1;
                end else begin
                    x_d = x_q - 10'(STEP_X);
                end
                if (dy_q) begin
                    if (ny >= 10'(MAX_Y)) begin
                        y_d      = 9'(MAX_Y);
                        dy_d     = 1'b0;
                        bounce_y = 1'b1;
                    end else begin
                        y_d = ny[8:0];
                    end
                end else if (y_q <= 9'(STEP_Y)) begin
                    y_d      = '0;
                    dy_d     = 1'b1;
                    bounce_y = 1'b1;
                end else begin
                    y_d = y_q - 9'(STEP_Y);
                end
                if (bounce_x || bounce_y) begin
                    hue_d = hue_q + 1'b1;
                end
                if (bounce_x && bounce_y) begin
                    corner_d = 1'b1;
                    if (cc_q != 16'hFFFF) begin
                        cc_d = cc_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_25_175 or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_ARM;
            frame_q  <= '0;
            tick_q   <= 1'b0;
            div_q    <= '0;
            x_q      <= 10'(INIT_X);
            y_q      <= 9'(INIT_Y);
            dx_q     <= 1'b1;
            dy_q     <= 1'b1;
            hue_q    <= '0;
            corner_q <= 1'b0;
            cc_q     <= '0;
        end else begin
            state_q  <= state_d;
            frame_q  <= bus.frame;
            tick_q   <= tick_d;
            div_q    <= div_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            hue_q    <= hue_d;
            corner_q <= corner_d;
            cc_q     <= cc_d;
        end
    end

    assign bus.logo_x       = x_q;
    assign bus.logo_y       = y_q;
    assign bus.hue          = hue_q;
    assign bus.dir_x        = dx_q;
    assign bus.dir_y        = dy_q;
    assign bus.corner_hit   = corner_q;
    assign bus.corner_count = cc_q;
endmodule
